// File: rtl/shift_reg_univ.sv
// Universal shift register with direct-mode operations and a counted
// multi-cycle burst of any shift/rotate op.
//
// state | meaning
// IDLE  | ops applied directly each edge; a start with a shift op launches a burst
// RUN   | latched shift op applied once per edge until the remaining count expires
// DONE  | one-cycle completion pulse, Q held, then back to IDLE
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] Q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_SHL   = 3'b001;
  localparam logic [2:0] OP_SHR   = 3'b010;
  localparam logic [2:0] OP_ROL   = 3'b011;
  localparam logic [2:0] OP_ROR   = 3'b100;
  localparam logic [2:0] OP_ASR   = 3'b101;
  localparam logic [2:0] OP_LOAD  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [2:0]       op_lat;
  logic [CNT_W-1:0] cnt_rem;
  logic [WIDTH-1:0] q_reg;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sh_q;
  logic             sh_bit;
  logic             op_is_shift;

  assign Q = q_reg;
  assign op_is_shift = (op >= OP_SHL) && (op <= OP_ASR);

  // Shift/rotate result and ejected bit for the op in effect this cycle
  always_comb begin
    sel_op = (state == RUN) ? op_lat : op;
    sh_q   = q_reg;
    sh_bit = 1'b0;
    case (sel_op)
      OP_SHL: begin sh_q = {q_reg[WIDTH-2:0], ser_in};        sh_bit = q_reg[WIDTH-1]; end
      OP_SHR: begin sh_q = {ser_in, q_reg[WIDTH-1:1]};        sh_bit = q_reg[0];       end
      OP_ROL: begin sh_q = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]}; sh_bit = q_reg[WIDTH-1]; end
      OP_ROR: begin sh_q = {q_reg[0], q_reg[WIDTH-1:1]};      sh_bit = q_reg[0];       end
      OP_ASR: begin sh_q = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]}; sh_bit = q_reg[0];      end
      default: begin sh_q = q_reg; sh_bit = 1'b0; end
    endcase
  end

  // FSM, data register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_lat  <= OP_HOLD;
      cnt_rem <= '0;
      q_reg   <= '0;
      ser_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && op_is_shift) begin
            if (count != '0) begin
              op_lat  <= op;
              cnt_rem <= count;
              state   <= RUN;
              busy    <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            case (op)
              OP_HOLD:  ;
              OP_LOAD:  q_reg <= par_in;
              OP_CLEAR: q_reg <= '0;
              default: begin
                q_reg   <= sh_q;
                ser_out <= sh_bit;
              end
            endcase
          end
        end
        RUN: begin
          q_reg   <= sh_q;
          ser_out <= sh_bit;
          cnt_rem <= cnt_rem - CNT_ONE;
          if (cnt_rem == CNT_ONE) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=8, CNT_W=4).
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] op = 3'b000;
  logic       ser_in = 1'b0;
  logic [7:0] par_in = 8'h00;
  logic       start = 1'b0;
  logic [3:0] count = 4'd0;
  logic [7:0] Q;
  logic       ser_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic       si;
    logic       start;
    logic [3:0] cnt;
    logic [7:0] par;
    logic [7:0] eq;
    logic       eso;
    logic       eb;
    logic       ed;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] eq;
    logic       eso;
    logic       eb;
    logic       ed;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[15];

  shift_reg_univ #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .ser_in(ser_in), .par_in(par_in),
    .start(start), .count(count), .Q(Q), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required end of test");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive inputs, push expectation, advance one edge, pop and compare
  task automatic step(input string name, input logic [2:0] o, input logic si, input logic st,
                      input logic [3:0] c, input logic [7:0] p, input logic [7:0] eq,
                      input logic eso, input logic eb, input logic ed);
    exp_t e;
    op = o; ser_in = si; start = st; count = c; par_in = p;
    sb.push_back('{name, eq, eso, eb, ed});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".Q"}, Q, e.eq);
    chk({e.name, ".ser_out"}, {7'b0, ser_out}, {7'b0, e.eso});
    chk({e.name, ".busy"}, {7'b0, busy}, {7'b0, e.eb});
    chk({e.name, ".done"}, {7'b0, done}, {7'b0, e.ed});
  endtask

  initial begin
    // op, si, start, cnt, par, Q, ser_out, busy, done
    vecs[0]  = '{3'b110, 1'b0, 1'b0, 4'd0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 1'b1, 1'b0, 4'd0, 8'h00, 8'h4B, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'b101, 1'b0, 1'b0, 4'd0, 8'h00, 8'h25, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'b000, 1'b1, 1'b0, 4'd0, 8'hFF, 8'h25, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'b110, 1'b0, 1'b0, 4'd0, 8'h90, 8'h90, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'b101, 1'b0, 1'b0, 4'd0, 8'h00, 8'hC8, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 1'b0, 1'b0, 4'd0, 8'h00, 8'h64, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b100, 1'b0, 1'b0, 4'd0, 8'h00, 8'h32, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b010, 1'b1, 1'b0, 4'd0, 8'h00, 8'h99, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b011, 1'b0, 1'b0, 4'd0, 8'h00, 8'h33, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b100, 1'b0, 1'b0, 4'd0, 8'h00, 8'h99, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'b001, 1'b0, 1'b0, 4'd0, 8'h00, 8'h32, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{3'b111, 1'b1, 1'b0, 4'd0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3'b110, 1'b0, 1'b1, 4'd3, 8'h81, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{3'b000, 1'b0, 1'b1, 4'd2, 8'h00, 8'h81, 1'b1, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("reset.Q", Q, 8'h00);
    chk("reset.ser_out", {7'b0, ser_out}, 8'h00);
    chk("reset.busy", {7'b0, busy}, 8'h00);
    chk("reset.done", {7'b0, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Direct-mode vectors
    for (int i = 0; i < 15; i++)
      step($sformatf("vec%0d", i), vecs[i].op, vecs[i].si, vecs[i].start, vecs[i].cnt,
           vecs[i].par, vecs[i].eq, vecs[i].eso, vecs[i].eb, vecs[i].ed);

    // ROL burst of 3 from 81; op switched to clear mid-burst must be ignored
    step("burst_start", 3'b011, 1'b0, 1'b1, 4'd3, 8'h00, 8'h81, 1'b1, 1'b1, 1'b0);
    step("burst_s1",    3'b111, 1'b0, 1'b0, 4'd0, 8'h00, 8'h03, 1'b1, 1'b1, 1'b0);
    step("burst_s2",    3'b111, 1'b1, 1'b1, 4'd7, 8'hFF, 8'h06, 1'b0, 1'b1, 1'b0);
    step("burst_s3",    3'b111, 1'b0, 1'b0, 4'd0, 8'h00, 8'h0C, 1'b0, 1'b0, 1'b1);
    // start during DONE ignored
    step("done_start",  3'b001, 1'b1, 1'b1, 4'd2, 8'h00, 8'h0C, 1'b0, 1'b0, 1'b0);
    step("post_idle",   3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 8'h0C, 1'b0, 1'b0, 1'b0);

    // Zero-count burst: straight to DONE, Q unchanged, busy never rises
    step("zero_start",  3'b001, 1'b1, 1'b1, 4'd0, 8'h00, 8'h0C, 1'b0, 1'b0, 1'b1);
    step("zero_after",  3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 8'h0C, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN
    step("pre_load",    3'b110, 1'b0, 1'b0, 4'd0, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0);
    step("arst_start",  3'b011, 1'b0, 1'b1, 4'd5, 8'h00, 8'hF0, 1'b0, 1'b1, 1'b0);
    step("arst_s1",     3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 8'hE1, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.Q", Q, 8'h00);
    chk("arst.ser_out", {7'b0, ser_out}, 8'h00);
    chk("arst.busy", {7'b0, busy}, 8'h00);
    chk("arst.done", {7'b0, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step("rel_hold",    3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step("rel_load",    3'b110, 1'b0, 1'b0, 4'd0, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
